// File: rtl/npc_lsu.sv
// Load/store unit: turns one decoded memory request into a single word-aligned bus
// transaction with byte strobes and returns a one-cycle, extended response.
module npc_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rd_en,
  input  logic        req_wr_en,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        op_q, op_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic        op_illegal;
  logic        misaligned;
  logic [31:0] lane;
  logic [31:0] ld_data;
  logic        timeout_hit;

  // Store lane replication and strobes, from the live request (only used in IDLE).
  always_comb begin
    st_wdata = req_wdata;
    st_wstrb = 4'b1111;
    case (req_op[1:0])
      2'b00: begin
        st_wdata = {4{req_wdata[7:0]}};
        st_wstrb = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{req_wdata[15:0]}};
        st_wstrb = 4'b0011 << req_addr[1:0];
      end
      default: begin
        st_wdata = req_wdata;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    if (req_rd_en) begin
      op_illegal = (req_op == 3'b011) || (req_op == 3'b110) || (req_op == 3'b111);
    end else begin
      op_illegal = req_op[2] || (req_op[1:0] == 2'b11);
    end
    misaligned = ((req_op[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_op[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  // Load extraction: shift the addressed lane down, then extend by op[2].
  always_comb begin
    lane = bus_rdata >> {addr_q[1:0], 3'b000};
    case (op_q[1:0])
      2'b00:   ld_data = {{24{~op_q[2] & lane[7]}}, lane[7:0]};
      2'b01:   ld_data = {{16{~op_q[2] & lane[15]}}, lane[15:0]};
      default: ld_data = bus_rdata;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (32'(cnt_q) == TIMEOUT - 32'd1);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d    = req_wr_en;
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wr_en ? st_wdata : 32'd0;
          wstrb_d = req_wr_en ? st_wstrb : 4'd0;
          rdata_d = 32'd0;
          err_d   = 1'b0;
          if (!req_rd_en && !req_wr_en) begin
            state_d = StResp;
          end else if ((req_rd_en && req_wr_en) || op_illegal || misaligned) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (bus_gnt) begin
          cnt_d   = '0;
          state_d = we_q ? StResp : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_rvalid) begin
          rdata_d = ld_data;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (timeout_hit) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      op_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      cnt_q   <= '0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Bus and response fields are forced to zero outside the state that owns them.
  always_comb begin
    req_ready  = (state_q == StIdle);
    bus_req    = (state_q == StReq);
    bus_we     = bus_req & we_q;
    bus_addr   = bus_req ? {addr_q[31:2], 2'b00} : 32'd0;
    bus_wstrb  = bus_req ? wstrb_q : 4'd0;
    bus_wdata  = bus_req ? wdata_q : 32'd0;
    resp_valid = (state_q == StResp);
    resp_rdata = resp_valid ? rdata_q : 32'd0;
    resp_err   = resp_valid & err_q;
  end

endmodule
